// File: rtl/latch_bank_wr_ctrl.sv
// Write sequencer and round-robin arbiter for a bank of level-sensitive latch
// words. Each write runs SETUP -> OPEN -> HOLD so that data is settled before
// a gate rises and stays put until after it falls. Gates and the data bus are
// driven straight from flops, so the latch enables are glitch-free.
module latch_bank_wr_ctrl #(
  parameter int DEPTH       = 8,
  parameter int AW          = 3,
  parameter int DW          = 8,
  parameter int GATE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [AW-1:0]    a_addr,
  input  logic [DW-1:0]    a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [AW-1:0]    b_addr,
  input  logic [DW-1:0]    b_data,
  output logic             b_ready,
  output logic [DW-1:0]    lat_d,
  output logic [DEPTH-1:0] lat_gate,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // Gate-open counter width; GATE_CYCLES is at most 15.
  localparam int CW = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_OPEN  = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  // prio: 0 = requester A wins a tie, 1 = requester B wins a tie.
  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    lat_d_q, lat_d_d;
  logic [DEPTH-1:0] lat_gate_q, lat_gate_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [DEPTH-1:0] gate_sel;
  logic             addr_ok;
  logic             a_grant;
  logic             b_grant;

  // Arbitration: grants only in IDLE; a lone requester always wins, a tie goes to prio.
  always_comb begin
    a_grant = (state_q == S_IDLE) & a_valid & (~b_valid | ~prio_q);
    b_grant = (state_q == S_IDLE) & b_valid & (~a_valid | prio_q);
  end

  assign a_ready = a_grant;
  assign b_ready = b_grant;

  // Address decode: an address >= DEPTH matches no word, which also flags it as an error.
  always_comb begin
    gate_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      gate_sel[i] = (addr_q == AW'(i));
    end
    addr_ok = |gate_sel;
  end

  // Next-state logic for the write sequence and the registered outputs.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold the old value.
    state_d = state_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    lat_d_d = lat_d_q;

    case (state_q)
      S_IDLE: begin
        if (a_grant) begin
          addr_d  = a_addr;
          lat_d_d = a_data;
          prio_d  = 1'b1;
          state_d = S_SETUP;
        end else if (b_grant) begin
          addr_d  = b_addr;
          lat_d_d = b_data;
          prio_d  = 1'b0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = CW'(1);
        state_d = S_OPEN;
      end
      S_OPEN: begin
        if (cnt_q == CW'(GATE_CYCLES)) begin
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are computed from the next state so the flops show them in that state.
    lat_gate_d = (state_d == S_OPEN) ? gate_sel : '0;
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_HOLD) &  addr_ok;
    err_d      = (state_d == S_HOLD) & ~addr_ok;
  end

  // Control and output registers; lat_d is cleared only once every gate is already closed.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value; blocking here would create order-dependent races.
    if (rst) begin
      state_q    <= S_IDLE;
      prio_q     <= 1'b0;
      cnt_q      <= '0;
      lat_gate_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      if (lat_gate_q == '0) begin
        lat_d_q <= '0;
      end
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      cnt_q      <= cnt_d;
      lat_gate_q <= lat_gate_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      lat_d_q    <= lat_d_d;
    end
  end

  // Captured write address.
  always_ff @(posedge clk) begin
    // NOTE: the address register carries no reset; it is only read after an
    // accept has loaded it, so a reset would add wiring for no behaviour.
    addr_q <= addr_d;
  end

  assign lat_d    = lat_d_q;
  assign lat_gate = lat_gate_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_latch_bank_wr_ctrl.sv
// Self-checking bench for latch_bank_wr_ctrl: a cycle table for the default
// configuration, then hand sequences for a long gate, an out-of-range address
// and a reset landing in OPEN.
module tb_latch_bank_wr_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance 0: DEPTH 8, GATE_CYCLES 1
  logic       a0_valid, b0_valid, a0_ready, b0_ready;
  logic [2:0] a0_addr, b0_addr;
  logic [7:0] a0_data, b0_data, lat_d0, gate0;
  logic       busy0, done0, err0;
  // Instance 1: DEPTH 8, GATE_CYCLES 3
  logic       a1_valid, b1_valid, a1_ready, b1_ready;
  logic [2:0] a1_addr, b1_addr;
  logic [7:0] a1_data, b1_data, lat_d1, gate1;
  logic       busy1, done1, err1;
  // Instance 2: DEPTH 6, GATE_CYCLES 1
  logic       a2_valid, b2_valid, a2_ready, b2_ready;
  logic [2:0] a2_addr, b2_addr;
  logic [7:0] a2_data, b2_data, lat_d2;
  logic [5:0] gate2;
  logic       busy2, done2, err2;

  latch_bank_wr_ctrl #(.DEPTH(8), .AW(3), .DW(8), .GATE_CYCLES(1)) u_dut0 (
    .clk(clk), .rst(rst),
    .a_valid(a0_valid), .a_addr(a0_addr), .a_data(a0_data), .a_ready(a0_ready),
    .b_valid(b0_valid), .b_addr(b0_addr), .b_data(b0_data), .b_ready(b0_ready),
    .lat_d(lat_d0), .lat_gate(gate0), .busy(busy0), .done(done0), .err(err0)
  );

  latch_bank_wr_ctrl #(.DEPTH(8), .AW(3), .DW(8), .GATE_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst),
    .a_valid(a1_valid), .a_addr(a1_addr), .a_data(a1_data), .a_ready(a1_ready),
    .b_valid(b1_valid), .b_addr(b1_addr), .b_data(b1_data), .b_ready(b1_ready),
    .lat_d(lat_d1), .lat_gate(gate1), .busy(busy1), .done(done1), .err(err1)
  );

  latch_bank_wr_ctrl #(.DEPTH(6), .AW(3), .DW(8), .GATE_CYCLES(1)) u_dut2 (
    .clk(clk), .rst(rst),
    .a_valid(a2_valid), .a_addr(a2_addr), .a_data(a2_data), .a_ready(a2_ready),
    .b_valid(b2_valid), .b_addr(b2_addr), .b_data(b2_data), .b_ready(b2_ready),
    .lat_d(lat_d2), .lat_gate(gate2), .busy(busy2), .done(done2), .err(err2)
  );

  int applied = 0;
  int miscompares = 0;

  // Behavioural latch bank behind instance 0: a word follows lat_d while its gate is high.
  logic [7:0] mem0 [8];
  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (gate0[i]) mem0[i] <= lat_d0;
    end
  end

  // Per-cycle invariants.
  assert property (@(posedge clk) $onehot0(gate0))
    else begin miscompares++; $display("FAIL onehot0 gate0=%b", gate0); end
  assert property (@(posedge clk) $onehot0(gate1))
    else begin miscompares++; $display("FAIL onehot0 gate1=%b", gate1); end
  assert property (@(posedge clk) (gate0 != 8'h00) |=> ((gate0 == 8'h00) -> $stable(lat_d0)))
    else begin miscompares++; $display("FAIL lat_d0 moved on gate fall lat_d=%h", lat_d0); end
  assert property (@(posedge clk) (gate1 != 8'h00) |=> ((gate1 == 8'h00) -> $stable(lat_d1)))
    else begin miscompares++; $display("FAIL lat_d1 moved on gate fall lat_d=%h", lat_d1); end
  assert property (@(posedge clk) !(a0_ready && b0_ready))
    else begin miscompares++; $display("FAIL both ready high on dut0"); end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One cycle of instance 0: inputs, ready expected this cycle, outputs expected after the edge.
  typedef struct {
    logic       av;
    logic [2:0] aa;
    logic [7:0] ad;
    logic       bv;
    logic [2:0] ba;
    logic [7:0] bd;
    logic       ar;
    logic       br;
    logic [7:0] ld;
    logic [7:0] gate;
    logic       busy;
    logic       done;
    logic       err;
  } vec_t;

  function automatic vec_t v(input logic av, input logic [2:0] aa, input logic [7:0] ad,
                             input logic bv, input logic [2:0] ba, input logic [7:0] bd,
                             input logic ar, input logic br, input logic [7:0] ld,
                             input logic [7:0] gate, input logic busy, input logic done,
                             input logic err);
    vec_t r;
    r.av = av; r.aa = aa; r.ad = ad; r.bv = bv; r.ba = ba; r.bd = bd;
    r.ar = ar; r.br = br; r.ld = ld; r.gate = gate;
    r.busy = busy; r.done = done; r.err = err;
    return r;
  endfunction

  localparam int NV = 29;
  vec_t vecs [NV];

  initial begin
    // Both requesters held: grants alternate A, B, A, B, one every 4 cycles.
    for (int g = 0; g < 4; g++) begin
      automatic int  b0   = 1 + 4 * g;
      automatic bit  is_a = (g % 2 == 0);
      automatic logic [7:0] d = is_a ? 8'h11 : 8'h22;
      automatic logic [7:0] s = is_a ? 8'h02 : 8'h04;
      vecs[b0]     = v(1, 3'd1, 8'h11, 1, 3'd2, 8'h22, is_a, !is_a, d, 8'h00, 1, 0, 0);
      vecs[b0 + 1] = v(1, 3'd1, 8'h11, 1, 3'd2, 8'h22, 0, 0, d, s,     1, 0, 0);
      vecs[b0 + 2] = v(1, 3'd1, 8'h11, 1, 3'd2, 8'h22, 0, 0, d, 8'h00, 1, 1, 0);
      vecs[b0 + 3] = v(0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 0, d, 8'h00, 0, 0, 0);
    end
    vecs[0]  = v(0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    // Single A write to addr 5; inputs changed while busy are ignored.
    vecs[17] = v(1, 3'd5, 8'hA5, 0, 3'd0, 8'h00, 1, 0, 8'hA5, 8'h00, 1, 0, 0);
    vecs[18] = v(1, 3'd0, 8'h5A, 0, 3'd0, 8'h00, 0, 0, 8'hA5, 8'h20, 1, 0, 0);
    vecs[19] = v(0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 0, 8'hA5, 8'h00, 1, 1, 0);
    vecs[20] = v(0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 0, 8'hA5, 8'h00, 0, 0, 0);
    // prio now B, but a lone A is still served; B arriving mid-write is ignored.
    vecs[21] = v(1, 3'd3, 8'h3C, 0, 3'd0, 8'h00, 1, 0, 8'h3C, 8'h00, 1, 0, 0);
    vecs[22] = v(0, 3'd0, 8'h00, 1, 3'd6, 8'h99, 0, 0, 8'h3C, 8'h08, 1, 0, 0);
    vecs[23] = v(0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 0, 8'h3C, 8'h00, 1, 1, 0);
    vecs[24] = v(0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 0, 8'h3C, 8'h00, 0, 0, 0);
    // Lone B write to the lowest word.
    vecs[25] = v(0, 3'd0, 8'h00, 1, 3'd0, 8'h81, 0, 1, 8'h81, 8'h00, 1, 0, 0);
    vecs[26] = v(0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 0, 8'h81, 8'h01, 1, 0, 0);
    vecs[27] = v(0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 0, 8'h81, 8'h00, 1, 1, 0);
    vecs[28] = v(0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 0, 8'h81, 8'h00, 0, 0, 0);

    rst = 1'b1;
    {a0_valid, b0_valid, a1_valid, b1_valid, a2_valid, b2_valid} = '0;
    {a0_addr, b0_addr, a1_addr, b1_addr, a2_addr, b2_addr} = '0;
    {a0_data, b0_data, a1_data, b1_data, a2_data, b2_data} = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst.lat_d",    lat_d0,   0);
    check("rst.lat_gate", gate0,    0);
    check("rst.busy",     busy0,    0);
    check("rst.done",     done0,    0);
    check("rst.err",      err0,     0);
    check("rst.a_ready",  a0_ready, 0);
    check("rst.b_ready",  b0_ready, 0);
    rst = 1'b0;

    // Table-driven run on instance 0.
    for (int i = 0; i < NV; i++) begin
      a0_valid = vecs[i].av; a0_addr = vecs[i].aa; a0_data = vecs[i].ad;
      b0_valid = vecs[i].bv; b0_addr = vecs[i].ba; b0_data = vecs[i].bd;
      #1;
      check($sformatf("v%0d.a_ready", i), a0_ready, vecs[i].ar);
      check($sformatf("v%0d.b_ready", i), b0_ready, vecs[i].br);
      @(posedge clk);
      #1;
      check($sformatf("v%0d.lat_d", i),    lat_d0, vecs[i].ld);
      check($sformatf("v%0d.lat_gate", i), gate0,  vecs[i].gate);
      check($sformatf("v%0d.busy", i),     busy0,  vecs[i].busy);
      check($sformatf("v%0d.done", i),     done0,  vecs[i].done);
      check($sformatf("v%0d.err", i),      err0,   vecs[i].err);
    end
    a0_valid = 1'b0; b0_valid = 1'b0;

    check("latch.word1", mem0[1], 8'h11);
    check("latch.word2", mem0[2], 8'h22);
    check("latch.word5", mem0[5], 8'hA5);
    check("latch.word3", mem0[3], 8'h3C);
    check("latch.word0", mem0[0], 8'h81);

    // GATE_CYCLES=3: B writes word 7; gate high for exactly three cycles.
    b1_valid = 1'b1; b1_addr = 3'd7; b1_data = 8'hFF;
    #1;
    check("g3.b_ready", b1_ready, 1);
    check("g3.a_ready", a1_ready, 0);
    @(posedge clk);
    #1;
    b1_valid = 1'b0;
    check("g3.setup.lat_d", lat_d1, 8'hFF);
    check("g3.setup.gate",  gate1,  8'h00);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("g3.t%0d.gate", k),  gate1,  (k <= 3) ? 8'h80 : 8'h00);
      check($sformatf("g3.t%0d.lat_d", k), lat_d1, 8'hFF);
      check($sformatf("g3.t%0d.done", k),  done1,  (k == 4) ? 1 : 0);
      check($sformatf("g3.t%0d.busy", k),  busy1,  (k <= 4) ? 1 : 0);
    end

    // DEPTH=6: address 6 is sequenced but opens no gate and raises err.
    a2_valid = 1'b1; a2_addr = 3'd6; a2_data = 8'h66;
    #1;
    check("oor.a_ready", a2_ready, 1);
    @(posedge clk);
    #1;
    a2_valid = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      check($sformatf("oor.t%0d.gate", k), gate2, 6'h00);
      check($sformatf("oor.t%0d.err", k),  err2,  (k == 2) ? 1 : 0);
      check($sformatf("oor.t%0d.done", k), done2, 0);
      check($sformatf("oor.t%0d.busy", k), busy2, (k < 3) ? 1 : 0);
    end
    check("oor.lat_d", lat_d2, 8'h66);

    // Reset during OPEN: gate drops first, the data bus clears one edge later.
    a0_valid = 1'b1; a0_addr = 3'd4; a0_data = 8'h44;
    #1;
    check("rso.a_ready", a0_ready, 1);
    @(posedge clk);
    #1;
    a0_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rso.open.gate", gate0, 8'h10);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rso.r1.gate",  gate0,  8'h00);
    check("rso.r1.lat_d", lat_d0, 8'h44);
    check("rso.r1.done",  done0,  0);
    check("rso.r1.busy",  busy0,  0);
    @(posedge clk);
    #1;
    check("rso.r2.lat_d", lat_d0, 8'h00);
    check("rso.r2.done",  done0,  0);
    check("rso.latch4",   mem0[4], 8'h44);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rso.after.done", done0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
